// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE -> ACCESS -> RESP per request, sub-word stores by read-modify-write.
// Optional misalignment trapping is enabled by defining MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic                    illegal;
    logic                    misalign;
    logic [4:0]              byte_shift;
    logic [4:0]              half_shift;
    logic [7:0]              byte_lane;
    logic [15:0]             half_lane;
    logic [DATA_WIDTH-1:0]   load_data;
    logic [DATA_WIDTH-1:0]   merged;

    // Request decode is evaluated at acceptance so the error is known before ACCESS.
    always_comb begin
        illegal = req_we ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                         : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
`ifdef MISALIGN_TRAP_EN
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
    end

    // Lane selection ignores the offending low bits when trapping is off.
    always_comb begin
        byte_shift = {addr_q[1:0], 3'b000};
        half_shift = {addr_q[1], 4'b0000};
        byte_lane  = mem_rd_data[byte_shift +: 8];
        half_lane  = mem_rd_data[half_shift +: 16];

        case (funct3_q)
            3'b000:  load_data = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
            3'b001:  load_data = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
            3'b010:  load_data = mem_rd_data;
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_lane};
            default: load_data = '0;
        endcase

        merged = mem_rd_data;
        case (funct3_q[1:0])
            2'b00:   merged[byte_shift +: 8]  = wdata_q[7:0];
            2'b01:   merged[half_shift +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = illegal || misalign;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d = (!we_q && !err_q) ? load_data : '0;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // Outputs decode from the state register, so reset clears them asynchronously.
    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign resp_rdata  = rdata_q;
    assign resp_err    = (state_q == RESP) && err_q;
    assign mem_wr_en   = (state_q == ACCESS) && we_q && !err_q;
    assign mem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_wr_data = merged;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random traffic
// against a byte-array memory model; honours MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    int checks = 0;
    int errors = 0;

    // Word memory the DUT drives; the reference lives separately as bytes.
    logic [31:0] tb_mem [0:63] = '{default: '0};
    logic [7:0]  ref_mem [0:255] = '{default: '0};

    always #5 clk = ~clk;

    assign mem_rd_data = tb_mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_wr_en) tb_mem[mem_addr[7:2]] <= mem_wr_data;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        logic [7:0] wa;
        wa = {a[7:2], 2'b00};
        return {ref_mem[wa + 8'd3], ref_mem[wa + 8'd2], ref_mem[wa + 8'd1], ref_mem[wa]};
    endfunction

    // Full transaction: drive, check timing of every phase, compare with the model.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [7:0] a,
                          input logic [31:0] wd, input string tag);
        logic        illegal, mis, exp_err;
        logic [7:0]  ha, wa, b;
        logic [15:0] h;
        logic [31:0] exp_rdata;

        illegal = we ? (f3[2] || f3[1:0] == 2'b11) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
`endif
        exp_err   = illegal || mis;
        ha        = {a[7:1], 1'b0};
        wa        = {a[7:2], 2'b00};
        b         = ref_mem[a];
        h         = {ref_mem[ha + 8'd1], ref_mem[ha]};
        exp_rdata = 32'h0;
        if (!we && !exp_err) begin
            case (f3)
                3'd0: exp_rdata = 32'($signed(b));
                3'd1: exp_rdata = 32'($signed(h));
                3'd2: exp_rdata = ref_word(a);
                3'd4: exp_rdata = {24'h0, b};
                3'd5: exp_rdata = {16'h0, h};
                default: exp_rdata = 32'h0;
            endcase
        end
        if (we && !exp_err) begin
            case (f3[1:0])
                2'd0: ref_mem[a] = wd[7:0];
                2'd1: begin ref_mem[ha] = wd[7:0]; ref_mem[ha + 8'd1] = wd[15:8]; end
                default: begin
                    ref_mem[wa]        = wd[7:0];
                    ref_mem[wa + 8'd1] = wd[15:8];
                    ref_mem[wa + 8'd2] = wd[23:16];
                    ref_mem[wa + 8'd3] = wd[31:24];
                end
            endcase
        end

        @(negedge clk);
        check({tag, " ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = {24'h0, a}; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, " access_ready"}, 32'(req_ready), 32'd0);
        check({tag, " access_valid"}, 32'(resp_valid), 32'd0);
        check({tag, " access_wr_en"}, 32'(mem_wr_en), 32'(we && !exp_err));
        check({tag, " access_addr"}, mem_addr, {24'h0, wa});
        @(posedge clk); #1;
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, " resp_rdata"}, resp_rdata, exp_rdata);
        check({tag, " resp_err"}, 32'(resp_err), 32'(exp_err));
        check({tag, " resp_wr_en"}, 32'(mem_wr_en), 32'd0);
        @(posedge clk); #1;
        check({tag, " back_valid"}, 32'(resp_valid), 32'd0);
        check({tag, " back_ready"}, 32'(req_ready), 32'd1);
        if (we) check({tag, " mem_word"}, tb_mem[a[7:2]], ref_word(a));
    endtask

    initial begin
        int resp_cnt;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst ready", 32'(req_ready), 32'd1);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst rdata", resp_rdata, 32'h0);
        check("rst err", 32'(resp_err), 32'd0);
        check("rst wr_en", 32'(mem_wr_en), 32'd0);
        check("rst mem_addr", mem_addr, 32'h0);
        @(negedge clk); reset = 1'b0;

        // Reset during ACCESS of a store: write enable must drop before any write edge.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("midrst wr_en_before", 32'(mem_wr_en), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst wr_en_async", 32'(mem_wr_en), 32'd0);
        check("midrst ready", 32'(req_ready), 32'd1);
        @(negedge clk); reset = 1'b0;
        resp_cnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (resp_valid) resp_cnt++;
        end
        check("midrst no_resp", 32'(resp_cnt), 32'd0);
        check("midrst ready_after", 32'(req_ready), 32'd1);
        check("midrst mem_untouched", tb_mem[16], 32'h0);

        do_req(1'b1, 3'd2, 8'h10, 32'hDEADBEEF, "sw10");
        do_req(1'b0, 3'd2, 8'h10, 32'h0, "lw10");
        do_req(1'b1, 3'd0, 8'h11, 32'h00000055, "sb11");
        do_req(1'b0, 3'd2, 8'h10, 32'h0, "lw10_sb");
        do_req(1'b0, 3'd0, 8'h13, 32'h0, "lb13");
        do_req(1'b0, 3'd4, 8'h13, 32'h0, "lbu13");
        do_req(1'b1, 3'd2, 8'h10, 32'hDEADBEEF, "sw10_again");
        do_req(1'b1, 3'd1, 8'h12, 32'h00008001, "sh12");
        do_req(1'b0, 3'd1, 8'h12, 32'h0, "lh12");
        do_req(1'b0, 3'd5, 8'h12, 32'h0, "lhu12");
        do_req(1'b0, 3'd2, 8'h10, 32'h0, "lw10_sh");
        do_req(1'b0, 3'd2, 8'h12, 32'h0, "lw12_misal");
        do_req(1'b1, 3'd1, 8'h11, 32'h0000CAFE, "sh11_misal");
        do_req(1'b0, 3'd3, 8'h10, 32'h0, "ld_f3_011");
        do_req(1'b1, 3'd4, 8'h10, 32'hFFFFFFFF, "st_f3_100");

        // req_valid held through ACCESS/RESP with changing payload: only one acceptance.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5;
        {ref_mem[8'h23], ref_mem[8'h22], ref_mem[8'h21], ref_mem[8'h20]} = 32'hA5A5A5A5;
        resp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin req_wdata = 32'h5A5A5A5A; req_addr = 32'h24; end
            if (resp_valid) resp_cnt++;
        end
        @(negedge clk); req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (resp_valid) resp_cnt++;
        end
        check("hold resp_count", 32'(resp_cnt), 32'd1);
        check("hold mem20", tb_mem[8], ref_word(8'h20));
        check("hold mem24", tb_mem[9], ref_word(8'h24));

        for (int n = 0; n < 80; n++) begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   8'($urandom_range(0, 63)), $urandom, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
